// File: rtl/f2_key_pkg.sv
// Shared constants for the F2 key front end: default timing and key bit positions.
package f2_key_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;     // 10 ms at 50 MHz
    localparam int REPEAT_CYCLES_DEF   = 25000000;   // 0.5 s at 50 MHz

    localparam int NUM_KEYS = 4;

    localparam int KEY_BACK = 3;
    localparam int KEY_FWD  = 2;
    localparam int KEY_ROT  = 1;
    localparam int KEY_NEG  = 0;

    localparam logic KEY_IDLE_LEVEL    = 1'b1;
    localparam logic SWITCH_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/f2_debounce.sv
// Single-bit 2-flop synchronizer plus counter debouncer; stable follows raw after
// DEBOUNCE_CYCLES consecutive mismatching cycles, any bounce restarts the count.
module f2_debounce
    import f2_key_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          synced;
    logic [CW-1:0] cnt;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= RESET_LEVEL;
            synced    <= RESET_LEVEL;
            stable    <= RESET_LEVEL;
            cnt       <= '0;
        end else begin
            sync_meta <= raw;
            synced    <= sync_meta;
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // DEBOUNCE_CYCLES-th consecutive mismatch: accept the new level
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/f2_keyscan.sv
// Debounced key scanner: one-cycle press pulses (plus auto-repeat) and debounced auto switch.
// Pulse lands 2+DEBOUNCE_CYCLES+1 edges after a clean press; repeats every REPEAT_CYCLES in auto mode.
module f2_keyscan
    import f2_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [3:0] raw_keys,
    input  logic       raw_switch,
    output logic [3:0] func2_keys,
    output logic       func2_auto_switch
);

    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [NUM_KEYS-1:0] key_stable;
    logic [NUM_KEYS-1:0] key_stable_d;
    logic [NUM_KEYS-1:0] press;
    logic                switch_stable;
    logic [RW-1:0]       rep_cnt [NUM_KEYS];

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        f2_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (KEY_IDLE_LEVEL)
        ) u_key_db (
            .sysclk (sysclk),
            .rst_n  (rst_n),
            .raw    (raw_keys[i]),
            .stable (key_stable[i])
        );
    end

    f2_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (SWITCH_IDLE_LEVEL)
    ) u_switch_db (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .raw    (raw_switch),
        .stable (switch_stable)
    );

    // Keys are active-low, so a press is the stable level falling 1->0.
    assign press = key_stable_d & ~key_stable;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            key_stable_d      <= {NUM_KEYS{KEY_IDLE_LEVEL}};
            func2_keys        <= '0;
            func2_auto_switch <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            key_stable_d      <= key_stable;
            func2_auto_switch <= switch_stable;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (press[i]) begin
                    func2_keys[i] <= 1'b1;
                    rep_cnt[i]    <= '0;
                end else if (key_stable[i] || !func2_auto_switch) begin
                    // released or manual mode: counter parked at 0
                    func2_keys[i] <= 1'b0;
                    rep_cnt[i]    <= '0;
                end else if (rep_cnt[i] == REP_LAST) begin
                    func2_keys[i] <= 1'b1;
                    rep_cnt[i]    <= '0;
                end else begin
                    func2_keys[i] <= 1'b0;
                    rep_cnt[i]    <= rep_cnt[i] + RW'(1);
                end
            end
        end
    end

endmodule
